// File: rtl/sram_like_responder_pkg.sv
// Shared encodings for the sram-like responder: transfer sizes, data width and
// the byte-enable decode used when driving the RAM.
package sram_like_responder_pkg;

    localparam int DW = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    // The reserved size behaves like a word access.
    function automatic logic [3:0] wen_decode(input logic       wr,
                                              input logic [1:0] size,
                                              input logic [1:0] addr_lo);
        logic [3:0] wen;
        wen = 4'h0;
        if (wr) begin
            case (size)
                SIZE_BYTE: wen = 4'b0001 << addr_lo;
                SIZE_HALF: wen = 4'b0011 << {addr_lo[1], 1'b0};
                default:   wen = 4'hf;
            endcase
        end
        return wen;
    endfunction

endpackage

// File: rtl/sram_like_responder_resp_fifo.sv
// In-order response FIFO: one entry per accepted request holding its write flag,
// remaining latency, captured read data and a data-captured flag.
module sram_like_responder_resp_fifo
    import sram_like_responder_pkg::*;
#(
    parameter int OUTST = 2,
    parameter int CW    = 1,
    parameter int PW    = 1,
    parameter int NW    = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_i,
    input  logic          push_wr_i,
    input  logic [CW-1:0] push_cnt_i,
    input  logic          pop_i,
    input  logic          cap_en_i,
    input  logic [PW-1:0] cap_idx_i,
    input  logic [DW-1:0] cap_data_i,
    output logic          head_wr_o,
    output logic [CW-1:0] head_cnt_o,
    output logic [DW-1:0] head_data_o,
    output logic          head_vld_o,
    output logic [PW-1:0] head_idx_o,
    output logic [PW-1:0] tail_idx_o,
    output logic          full_o,
    output logic          empty_o
);

    logic          wr_q   [OUTST];
    logic [CW-1:0] cnt_q  [OUTST];
    logic [DW-1:0] data_q [OUTST];
    logic          dvld_q [OUTST];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [NW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // A push into a slot that is also the capture target (OUTST=1 back-to-back)
    // must win, so it is written last.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < OUTST; i++) begin
                wr_q[i]   <= 1'b0;
                cnt_q[i]  <= '0;
                data_q[i] <= '0;
                dvld_q[i] <= 1'b0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < OUTST; i++) begin
                if (cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
            if (cap_en_i) begin
                data_q[cap_idx_i] <= cap_data_i;
                dvld_q[cap_idx_i] <= 1'b1;
            end
            if (push_i) begin
                wr_q[wr_ptr_q]   <= push_wr_i;
                cnt_q[wr_ptr_q]  <= push_cnt_i;
                data_q[wr_ptr_q] <= '0;
                dvld_q[wr_ptr_q] <= 1'b0;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_wr_o   = wr_q[rd_ptr_q];
    assign head_cnt_o  = cnt_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign head_vld_o  = dvld_q[rd_ptr_q];
    assign head_idx_o  = rd_ptr_q;
    assign tail_idx_o  = wr_ptr_q;
    assign full_o      = (count_q == NW'(OUTST));
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/sram_like_responder.sv
// Slave end of the sram-like bus in front of a 1-cycle synchronous RAM, with
// configurable response latency and addr_ok throttling; responses stay in order.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int OUTST    = 2,
    parameter int LATENCY  = 1,
    parameter int ADDR_GAP = 0,
    parameter int AW       = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req,
    input  logic          wr,
    input  logic [1:0]    size,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          addr_ok,
    output logic          data_ok,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic [3:0]    mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int GW = (ADDR_GAP > 0) ? $clog2(ADDR_GAP + 1) : 1;
    localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
    localparam int NW = $clog2(OUTST + 1);

    logic [GW-1:0] gap_q, gap_d;
    logic          cap_q;
    logic          cap_wr_q;
    logic [PW-1:0] cap_idx_q;
    logic [DW-1:0] rdata_q;

    logic          head_wr, head_vld, full, empty;
    logic [CW-1:0] head_cnt;
    logic [DW-1:0] head_data;
    logic [PW-1:0] head_idx, tail_idx;

    logic          head_ready, retire_now, full_eff, accept;
    logic [DW-1:0] head_rdata, cap_data;

    sram_like_responder_resp_fifo #(
        .OUTST (OUTST),
        .CW    (CW),
        .PW    (PW),
        .NW    (NW)
    ) u_resp_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (accept),
        .push_wr_i   (wr),
        .push_cnt_i  (CW'(LATENCY - 1)),
        .pop_i       (retire_now),
        .cap_en_i    (cap_q),
        .cap_idx_i   (cap_idx_q),
        .cap_data_i  (cap_data),
        .head_wr_o   (head_wr),
        .head_cnt_o  (head_cnt),
        .head_data_o (head_data),
        .head_vld_o  (head_vld),
        .head_idx_o  (head_idx),
        .tail_idx_o  (tail_idx),
        .full_o      (full),
        .empty_o     (empty)
    );

    // The RAM word for the entry accepted last cycle is on mem_rdata right now;
    // forwarding it lets LATENCY=1 answer in the cycle after accept.
    always_comb begin
        head_ready = head_vld || (cap_q && (cap_idx_q == head_idx));
        if (head_vld) begin
            head_rdata = head_data;
        end else if (head_wr) begin
            head_rdata = '0;
        end else begin
            head_rdata = mem_rdata;
        end
    end

    assign cap_data   = cap_wr_q ? '0 : mem_rdata;
    assign retire_now = !empty && (head_cnt == '0) && head_ready;
    assign full_eff   = full && !retire_now;
    assign addr_ok    = resetn && !full_eff && (gap_q == '0);
    assign accept     = req && addr_ok;

    assign mem_en    = accept;
    assign mem_wen   = accept ? wen_decode(wr, size, addr[1:0]) : 4'h0;
    assign mem_addr  = {addr[AW-1:2], 2'b00};
    assign mem_wdata = wdata;

    assign data_ok = retire_now;
    assign rdata   = retire_now ? head_rdata : rdata_q;

    always_comb begin
        if (accept) begin
            gap_d = GW'(ADDR_GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end else begin
            gap_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gap_q     <= '0;
            cap_q     <= 1'b0;
            cap_wr_q  <= 1'b0;
            cap_idx_q <= '0;
            rdata_q   <= '0;
        end else begin
            gap_q     <= gap_d;
            cap_q     <= accept;
            cap_wr_q  <= wr;
            cap_idx_q <= tail_idx;
            if (retire_now) begin
                rdata_q <= head_rdata;
            end
        end
    end

endmodule
